// File: rtl/lsab_serial_tx.sv
// lsab_serial_tx: drains 32-bit words from an LSAB channel and sends
// each one as four 8N1 bytes, low byte first, on a single idle-high wire.
module lsab_serial_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int LEN_W        = 24
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             RUN,
    input  logic [LEN_W-1:0] LEN,
    input  logic [31:0]      DATA_SEND,
    output logic             READ_FROM_LSAB,
    output logic             BUSY,
    output logic             IRQ,
    output logic             ERROR,
    input  logic             ERROR_ACK,
    output logic             WIRE_TX
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [2:0]       bit_q, bit_d;
    logic [1:0]       byte_q, byte_d;
    logic [LEN_W-1:0] words_q, words_d;
    logic [31:0]      word_q, word_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic             tx_q, tx_d;
    logic             bit_end;

    assign bit_end        = (timer_q == LAST);
    assign READ_FROM_LSAB = (state_q == S_FETCH);
    assign IRQ            = (state_q == S_DONE);
    assign BUSY           = busy_q;
    assign ERROR          = err_q;
    assign WIRE_TX        = tx_q;

    // Next-state, counters and the line level for the following cycle.
    always_comb begin
        state_d = state_q;
        timer_d = '0;
        bit_d   = bit_q;
        byte_d  = byte_q;
        words_d = words_q;
        word_d  = word_q;
        busy_d  = busy_q;
        tx_d    = 1'b1;

        if (state_q == S_START || state_q == S_DATA || state_q == S_STOP) begin
            timer_d = bit_end ? '0 : timer_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (RUN) begin
                    if (LEN != '0) begin
                        words_d = LEN;
                        busy_d  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                word_d  = DATA_SEND;
                byte_d  = 2'd0;
                state_d = S_START;
            end
            S_START: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                tx_d = word_q[{byte_q, bit_q}];
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (byte_q != 2'd3) begin
                        byte_d  = byte_q + 2'd1;
                        state_d = S_START;
                    end else if (words_q > LEN_W'(1)) begin
                        words_d = words_q - 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sticky overrun flag; a new overrun wins over a same-cycle ack.
    always_comb begin
        err_d = err_q;
        if (RUN && state_q != S_IDLE) begin
            err_d = 1'b1;
        end else if (ERROR_ACK) begin
            err_d = 1'b0;
        end
    end

    // State and datapath registers; reset forces the line high at once.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            words_q <= '0;
            word_q  <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            words_q <= words_d;
            word_q  <= word_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_lsab_serial_tx.sv
// tb_lsab_serial_tx: directed bench with an LSAB word source, a UART
// frame decoder and a byte scoreboard for lsab_serial_tx.
module tb_lsab_serial_tx;

    logic        CLK = 1'b0;
    logic        RST;
    logic        RUN;
    logic [23:0] LEN;
    logic [31:0] DATA_SEND;
    logic        READ_FROM_LSAB;
    logic        BUSY;
    logic        IRQ;
    logic        ERROR;
    logic        ERROR_ACK;
    logic        WIRE_TX;

    lsab_serial_tx #(.CLKS_PER_BIT(4), .LEN_W(24)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .RUN            (RUN),
        .LEN            (LEN),
        .DATA_SEND      (DATA_SEND),
        .READ_FROM_LSAB (READ_FROM_LSAB),
        .BUSY           (BUSY),
        .IRQ            (IRQ),
        .ERROR          (ERROR),
        .ERROR_ACK      (ERROR_ACK),
        .WIRE_TX        (WIRE_TX)
    );

    always #5 CLK = ~CLK;

    int          n_chk = 0;
    int          n_fail = 0;
    int          n_frames = 0;
    logic [31:0] word_q[$];
    logic [7:0]  exp_q[$];

    int   busy_n, irq_n, irq_k, read_n, low_n, rk[$];
    logic err_inj;
    logic wv [0:1023];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        word_q.push_back(w);
        for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
    endtask

    // LSAB source: word appears the cycle after the read strobe.
    always @(posedge CLK) begin
        if (READ_FROM_LSAB === 1'b1 && word_q.size() != 0)
            DATA_SEND <= word_q.pop_front();
        else
            DATA_SEND <= $urandom;
    end

    // Frame decoder sampling mid-cycle; checks every bit is 4 cycles wide.
    logic [39:0] mon_s;
    logic        mon_ab;
    logic        mon_ok;
    logic [7:0]  mon_b;
    always begin
        @(negedge CLK);
        if (RST === 1'b1 && WIRE_TX === 1'b0) begin
            mon_s    = '0;
            mon_ab   = 1'b0;
            mon_s[0] = WIRE_TX;
            for (int k = 1; k < 40; k++) begin
                @(negedge CLK);
                mon_s[k] = WIRE_TX;
                if (RST !== 1'b1) mon_ab = 1'b1;
            end
            if (!mon_ab) begin
                mon_ok = (mon_s[3:0] == 4'h0) && (mon_s[39:36] == 4'hF);
                for (int g = 0; g < 10; g++)
                    for (int j = 1; j < 4; j++)
                        if (mon_s[4*g+j] !== mon_s[4*g]) mon_ok = 1'b0;
                for (int i = 0; i < 8; i++) mon_b[i] = mon_s[4 + 4*i];
                n_frames++;
                chk("frame_shape", {31'd0, mon_ok}, 32'd1);
                chk("sb_has_entry", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0)
                    chk("byte_value", {24'd0, mon_b}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic run_xfer(input logic [23:0] len, input int budget,
                            input int inj_k, input logic [23:0] inj_len,
                            input logic inj_ack);
        bit done;
        busy_n = 0; irq_n = 0; irq_k = -1; read_n = 0; low_n = 0;
        err_inj = 1'b0;
        rk.delete();
        done = 0;
        RUN = 1'b1;
        LEN = len;
        tick();
        RUN = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            wv[k] = WIRE_TX;
            busy_n += int'(BUSY);
            read_n += int'(READ_FROM_LSAB);
            if (READ_FROM_LSAB) rk.push_back(k);
            if (WIRE_TX == 1'b0) low_n++;
            if (IRQ) begin
                irq_n++;
                irq_k = k;
            end
            if (k == inj_k + 1) err_inj = ERROR;
            if (irq_n != 0 && k >= irq_k + 3) done = 1;
            if (k == inj_k) begin
                RUN = 1'b1;
                LEN = inj_len;
                ERROR_ACK = inj_ack;
            end
            tick();
            RUN = 1'b0;
            ERROR_ACK = 1'b0;
        end
        chk("xfer_done", {31'd0, done}, 32'd1);
    endtask

    task automatic check_single(input string p);
        push_word(32'h44332211);
        run_xfer(24'd1, 400, -10, 24'd0, 1'b0);
        chk({p, "_reads"}, read_n, 1);
        chk({p, "_read_k"}, rk.size() != 0 ? rk[0] : -1, 0);
        chk({p, "_wire_k0"}, {31'd0, wv[0]}, 1);
        chk({p, "_wire_k2"}, {31'd0, wv[2]}, 1);
        chk({p, "_wire_fall"}, {31'd0, wv[3]}, 0);
        chk({p, "_irq_k"}, irq_k, 162);
        chk({p, "_irq_n"}, irq_n, 1);
        chk({p, "_busy_n"}, busy_n, 163);
        repeat (5) tick();
    endtask

    int irq_seen, rd_seen, hi_run;

    initial begin
        RST = 1'b0; RUN = 1'b0; LEN = '0; ERROR_ACK = 1'b0;
        repeat (3) tick();
        chk("rst_wire", {31'd0, WIRE_TX}, 1);
        chk("rst_read", {31'd0, READ_FROM_LSAB}, 0);
        chk("rst_busy", {31'd0, BUSY}, 0);
        chk("rst_irq", {31'd0, IRQ}, 0);
        chk("rst_error", {31'd0, ERROR}, 0);
        RST = 1'b1;
        repeat (3) tick();

        check_single("single");

        push_word(32'hA5A5A5A5);
        push_word(32'h00000000);
        push_word(32'hFFFFFFFF);
        run_xfer(24'd3, 800, -10, 24'd0, 1'b0);
        chk("multi_reads", read_n, 3);
        chk("multi_gap01", rk.size() == 3 ? rk[1] - rk[0] : -1, 162);
        chk("multi_gap12", rk.size() == 3 ? rk[2] - rk[1] : -1, 162);
        chk("multi_irq_n", irq_n, 1);
        chk("multi_irq_k", irq_k, 486);
        chk("multi_busy_n", busy_n, 487);
        hi_run = 0;
        for (int k = 321; k <= 326; k++) hi_run += int'(wv[k]);
        chk("multi_idle_hi", hi_run, 6);
        chk("multi_last_bit", {31'd0, wv[320]}, 0);
        chk("multi_next_start", {31'd0, wv[327]}, 0);
        repeat (5) tick();

        run_xfer(24'd0, 20, -10, 24'd0, 1'b0);
        chk("zero_reads", read_n, 0);
        chk("zero_irq_k", irq_k, 0);
        chk("zero_irq_n", irq_n, 1);
        chk("zero_busy", busy_n, 0);
        chk("zero_wire_low", low_n, 0);
        repeat (3) tick();

        push_word(32'h87654321);
        push_word(32'h0F1E2D3C);
        run_xfer(24'd2, 800, 50, 24'd5, 1'b0);
        chk("ovr_err_rise", {31'd0, err_inj}, 1);
        chk("ovr_reads", read_n, 2);
        chk("ovr_irq_k", irq_k, 324);
        chk("ovr_busy_n", busy_n, 325);
        repeat (4) tick();
        chk("ovr_err_hold", {31'd0, ERROR}, 1);
        ERROR_ACK = 1'b1;
        tick();
        ERROR_ACK = 1'b0;
        chk("ovr_err_ack", {31'd0, ERROR}, 0);

        push_word(32'hC0FFEE99);
        run_xfer(24'd1, 400, 20, 24'd7, 1'b1);
        chk("ovr2_set_wins", {31'd0, err_inj}, 1);
        chk("ovr2_reads", read_n, 1);
        chk("ovr2_irq_k", irq_k, 162);
        ERROR_ACK = 1'b1;
        tick();
        ERROR_ACK = 1'b0;
        chk("ovr2_err_ack", {31'd0, ERROR}, 0);
        repeat (3) tick();

        push_word(32'h5A5A5A00);
        RUN = 1'b1;
        LEN = 24'd1;
        tick();
        RUN = 1'b0;
        repeat (9) tick();
        chk("rstm_pre_wire", {31'd0, WIRE_TX}, 0);
        #2;
        RST = 1'b0;
        #1;
        chk("rstm_wire", {31'd0, WIRE_TX}, 1);
        chk("rstm_read", {31'd0, READ_FROM_LSAB}, 0);
        chk("rstm_busy", {31'd0, BUSY}, 0);
        chk("rstm_irq", {31'd0, IRQ}, 0);
        chk("rstm_error", {31'd0, ERROR}, 0);
        exp_q.delete();
        word_q.delete();
        irq_seen = 0;
        rd_seen = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (c == 3) RST = 1'b1;
            irq_seen += int'(IRQ);
            rd_seen += int'(READ_FROM_LSAB);
        end
        chk("rstm_no_irq", irq_seen, 0);
        chk("rstm_no_read", rd_seen, 0);

        check_single("fresh");

        repeat (10) tick();
        chk("sb_empty", exp_q.size(), 0);
        chk("frames", n_frames, 32);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lsab_serial_tx.md
Name: lsab_serial_tx

Overview:
- LSAB drain-side peripheral. Consumes 32-bit words that the core pushes through an LSAB channel's cw port (read_cw / data_cw / err_cw / errack_cw, plus ph_len / ph_enstb).
- Serialises each word as four 8N1 bytes onto a single wire.
- Occupies one peripheral slot of special_snowflake_core, beside the Ethernet block. Completion is reported on the slot's int_cr line.

Parameters:
- CLKS_PER_BIT, 16: CLK cycles per serial bit; legal range 2..65535.
- LEN_W, 24: width of the word-count input.

Ports:
- CLK  in  1  single clock; LSAB side clock (CLK_n domain).
- RST  in  1  asynchronous, active-low reset.
- RUN  in  1  start strobe, one CLK cycle (from ph_enstb).
- LEN  in  LEN_W  number of 32-bit words to send; sampled on RUN.
- DATA_SEND  in  32  word from LSAB; valid the cycle after READ_FROM_LSAB.
- READ_FROM_LSAB  out  1  one-cycle read strobe to LSAB.
- BUSY  out  1  high from accepted RUN until completion.
- IRQ  out  1  one-cycle completion pulse.
- ERROR  out  1  sticky command-overrun flag.
- ERROR_ACK  in  1  clears ERROR.
- WIRE_TX  out  1  serial line; idle high.

Behaviour:
- Reset (RST low, asynchronous):
  - Outputs: WIRE_TX=1, READ_FROM_LSAB=0, BUSY=0, IRQ=0, ERROR=0.
  - State: FSM to IDLE, all counters cleared.
  - Reset mid-frame truncates the frame immediately. No further reads are issued. No IRQ is raised.
- States: IDLE, FETCH, LOAD, START, DATA, STOP, DONE.
- IDLE:
  - RUN with LEN!=0: latch LEN into words_left, set BUSY, go to FETCH.
  - RUN with LEN==0: go to DONE directly. No read is issued; BUSY stays 0.
- FETCH: READ_FROM_LSAB=1 for exactly this cycle, then go to LOAD.
- LOAD: capture DATA_SEND into shift_word, byte_idx=0, go to START.
- START:
  - WIRE_TX=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - Byte = shift_word[8*byte_idx+7 : 8*byte_idx]; byte 0 is bits [7:0], sent first.
- DATA: bits LSB first, each held CLKS_PER_BIT cycles; after bit 7 go to STOP.
- STOP: WIRE_TX=1 for CLKS_PER_BIT cycles, then:
  - byte_idx<3: increment byte_idx, go to START.
  - byte_idx==3 and words_left>1: decrement words_left, go to FETCH.
  - byte_idx==3 and words_left==1: go to DONE.
- DONE: IRQ=1 for one cycle, BUSY cleared on the same edge, go to IDLE.
- WIRE_TX is registered. It changes only on state/bit boundaries and is 1 in IDLE, FETCH, LOAD and DONE.
- Latency:
  - RUN sampled at edge n: READ_FROM_LSAB high during cycle n+1; WIRE_TX falls at edge n+3.
  - Per word: 40*CLKS_PER_BIT cycles of line time.
  - Inter-word gap: 2 idle-high cycles (FETCH + LOAD) after a stop bit.
- Counters:
  - Bit timer counts 0..CLKS_PER_BIT-1 and wraps.
  - words_left is LEN_W bits. LEN = 2^LEN_W-1 is legal; no wrap occurs because the count terminates at 1.
- Overrun / error handshake:
  - RUN while BUSY=1 (or while in DONE) is ignored for data purposes and sets ERROR.
  - ERROR stays high until a cycle with ERROR_ACK=1 clears it.
  - RUN-while-busy and ERROR_ACK in the same cycle: ERROR is set (set wins).
  - ERROR does not stop the transfer in progress.
- DATA_SEND is don't-care except in the LOAD cycle.

Test Plan (CLKS_PER_BIT=4):
- Single word:
  - Stimulus: RUN with LEN=1, LSAB word 0x44332211.
  - Required: exactly one READ_FROM_LSAB pulse. WIRE_TX sends bytes 0x11, 0x22, 0x33, 0x44, each as start bit, LSB-first data, stop bit, each bit 4 cycles wide.
  - Required: IRQ pulses one cycle after the last stop bit ends; BUSY is high for 1+1+160+1 cycles.
- Multi-word:
  - Stimulus: LEN=3, words 0xA5A5A5A5, 0x00000000, 0xFFFFFFFF.
  - Required: 3 read pulses spaced 162 cycles apart, 2-cycle idle-high gaps between words, a single IRQ at the end.
- Zero length:
  - Stimulus: RUN with LEN=0.
  - Required: no read pulse, WIRE_TX constant 1, IRQ high in cycle n+1, BUSY never high.
- Overrun:
  - Stimulus: second RUN (LEN=5) mid-word 0 of a LEN=2 transfer.
  - Required: ERROR rises, only 2 words are sent, ERROR holds until ERROR_ACK. Repeat with RUN and ERROR_ACK in the same cycle: ERROR stays 1.
- Reset mid-transfer:
  - Stimulus: RST low asynchronously during a DATA bit that is 0.
  - Required: WIRE_TX=1 with no clock edge, all outputs at reset values, no IRQ afterwards. A fresh RUN with LEN=1 then behaves as in the single-word test.
